// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch flush
// and a fixed-latency freeze for multi-cycle EX operations, plus a saturating stall counter.
//
// state | meaning
// RUN   | normal issue; reacts to mult_start, load-use and branch_taken
// STALL | single cycle after a load-use bubble; load-use ignored
// MULT  | multi-cycle EX op in progress; front end frozen until cnt reaches 1
module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_Rs,
    input  logic [4:0]       id_Rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_Rs,
    input  logic [4:0]       ex_Rt,
    input  logic             ex_MemRead,
    input  logic             mem_RegWrite,
    input  logic [4:0]       mem_dst,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_dst,
    input  logic             branch_taken,
    input  logic             mult_start,
    output logic             pc_ld,
    output logic             ifid_ld,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             mult_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, STALL, MULT} state_t;

    localparam logic [7:0] MULT_INIT = 8'(MULT_LAT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       load_use;
    logic       freeze;
    logic       lu_stall;

    always_comb begin
        load_use = ex_MemRead && (ex_Rt != 5'd0) &&
                   ((ex_Rt == id_Rs) || (id_uses_rt && (ex_Rt == id_Rt)));
        freeze   = (state == MULT) || mult_start;
        lu_stall = (state == RUN) && !mult_start && load_use;
    end

    // Control outputs react in the same cycle as the hazard; reset overrides everything.
    always_comb begin
        pc_ld       = 1'b1;
        ifid_ld     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        fwdA        = 2'b00;
        fwdB        = 2'b00;
        if (!rst) begin
            pc_ld       = 1'b0;
            ifid_ld     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            if (freeze) begin
                pc_ld     = 1'b0;
                ifid_ld   = 1'b0;
                idex_hold = 1'b1;
            end else if (lu_stall) begin
                pc_ld       = 1'b0;
                ifid_ld     = 1'b0;
                idex_bubble = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
            end

            if (mem_RegWrite && mem_dst != 5'd0 && mem_dst == ex_Rs)
                fwdA = 2'b10;
            else if (wb_RegWrite && wb_dst != 5'd0 && wb_dst == ex_Rs)
                fwdA = 2'b01;

            if (mem_RegWrite && mem_dst != 5'd0 && mem_dst == ex_Rt)
                fwdB = 2'b10;
            else if (wb_RegWrite && wb_dst != 5'd0 && wb_dst == ex_Rt)
                fwdB = 2'b01;
        end
    end

    assign mult_busy = (state == MULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            case (state)
                MULT: begin
                    if (cnt == 8'd1)
                        state <= RUN;
                    else
                        cnt <= cnt - 8'd1;
                end
                default: begin
                    if (mult_start) begin
                        if (MULT_LAT > 1) begin
                            cnt   <= MULT_INIT;
                            state <= MULT;
                        end else begin
                            state <= RUN;
                        end
                    end else if (lu_stall) begin
                        state <= STALL;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= '0;
        else if (!pc_ld && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model and literal spot checks.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_Rs = '0, id_Rt = '0, ex_Rs = '0, ex_Rt = '0, mem_dst = '0, wb_dst = '0;
    logic       id_uses_rt = 0, ex_MemRead = 0, mem_RegWrite = 0, wb_RegWrite = 0;
    logic       branch_taken = 0, mult_start = 0;

    logic        pc_ld, ifid_ld, ifid_flush, idex_bubble, idex_hold, mult_busy;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stall_count;

    logic        s_pc_ld, s_ifid_ld, s_ifid_flush, s_idex_bubble, s_idex_hold, s_mult_busy;
    logic [1:0]  s_fwdA, s_fwdB;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_rt(id_uses_rt),
        .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_MemRead(ex_MemRead),
        .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst), .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst),
        .branch_taken(branch_taken), .mult_start(mult_start),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .idex_hold(idex_hold), .fwdA(fwdA), .fwdB(fwdB), .mult_busy(mult_busy),
        .stall_count(stall_count)
    );

    hazard_ctrl #(.MULT_LAT(LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_rt(id_uses_rt),
        .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_MemRead(ex_MemRead),
        .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst), .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst),
        .branch_taken(branch_taken), .mult_start(mult_start),
        .pc_ld(s_pc_ld), .ifid_ld(s_ifid_ld), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .idex_hold(s_idex_hold), .fwdA(s_fwdA), .fwdB(s_fwdB), .mult_busy(s_mult_busy),
        .stall_count(s_stall_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_RegWrite && mem_dst != 0 && mem_dst == src) return 2'b10;
        if (wb_RegWrite && wb_dst != 0 && wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // Model: remaining freeze cycles, whether the last cycle was a load-use bubble, total stalls.
    int m_freeze = 0;
    int m_stalls = 0;
    bit m_after_lu = 0;
    bit e_pc, e_ifid, e_flush, e_bubble, e_hold, e_busy, e_lu_now;
    logic [1:0] e_fa, e_fb;

    always @(negedge clk) begin
        bit lu;
        e_pc = 1; e_ifid = 1; e_flush = 0; e_bubble = 0; e_hold = 0; e_busy = 0;
        e_fa = 2'b00; e_fb = 2'b00; e_lu_now = 0;
        if (!rst) begin
            m_freeze = 0; m_stalls = 0; m_after_lu = 0;
            e_pc = 0; e_ifid = 0; e_bubble = 1;
        end else begin
            lu = ex_MemRead && ex_Rt != 0 && (ex_Rt == id_Rs || (id_uses_rt && ex_Rt == id_Rt));
            e_busy = (m_freeze > 0);
            if (m_freeze > 0 || mult_start) begin
                e_pc = 0; e_ifid = 0; e_hold = 1;
            end else if (lu && !m_after_lu) begin
                e_pc = 0; e_ifid = 0; e_bubble = 1; e_lu_now = 1;
            end else if (branch_taken) begin
                e_flush = 1;
            end
            e_fa = fwd_sel(ex_Rs);
            e_fb = fwd_sel(ex_Rt);
        end
        chk("pc_ld", pc_ld, e_pc);
        chk("ifid_ld", ifid_ld, e_ifid);
        chk("ifid_flush", ifid_flush, e_flush);
        chk("idex_bubble", idex_bubble, e_bubble);
        chk("idex_hold", idex_hold, e_hold);
        chk("mult_busy", mult_busy, e_busy);
        chk("fwdA", fwdA, e_fa);
        chk("fwdB", fwdB, e_fb);
        chk("stall_count", stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
        chk("sat_stall_count", s_stall_count, (m_stalls > 15) ? 15 : m_stalls);
        chk("sat_pc_ld", s_pc_ld, e_pc);
    end

    always @(posedge clk) begin
        if (rst) begin
            if (!e_pc) m_stalls++;
            if (m_freeze > 0) m_freeze--;
            else if (mult_start) m_freeze = LAT - 1;
            m_after_lu = e_lu_now;
        end
    end

    task automatic clear_hz();
        ex_MemRead = 0; ex_Rt = 0; id_Rs = 0; id_Rt = 0; id_uses_rt = 0;
        branch_taken = 0; mult_start = 0;
    endtask

    initial begin
        // reset: forwarding suppressed even with matching sources
        mem_RegWrite = 1; mem_dst = 5; ex_Rs = 5;
        step(2);
        chk("rst_pc_ld", pc_ld, 0);
        chk("rst_bubble", idex_bubble, 1);
        chk("rst_fwdA", fwdA, 0);
        chk("rst_count", stall_count, 0);
        rst = 1;
        mem_RegWrite = 0; mem_dst = 0; ex_Rs = 0;
        step(1);

        // forwarding priority
        ex_Rs = 5; mem_RegWrite = 1; mem_dst = 5; wb_RegWrite = 1; wb_dst = 5; #1;
        chk("fwd_mem", fwdA, 2'b10);
        mem_RegWrite = 0; #1;
        chk("fwd_wb", fwdA, 2'b01);
        mem_RegWrite = 1; mem_dst = 0; wb_dst = 0; #1;
        chk("fwd_r0", fwdA, 2'b00);
        ex_Rt = 7; wb_dst = 7; mem_dst = 6; #1;
        chk("fwdB_wb", fwdB, 2'b01);
        step(1);
        ex_Rs = 0; ex_Rt = 0; mem_RegWrite = 0; wb_RegWrite = 0; mem_dst = 0; wb_dst = 0;
        step(1);

        // load-use with Rs; held through the STALL cycle to show it is ignored there
        ex_MemRead = 1; ex_Rt = 3; id_Rs = 3; #1;
        chk("lu_pc_ld", pc_ld, 0);
        chk("lu_bubble", idex_bubble, 1);
        step(1);
        chk("stall_pc_ld", pc_ld, 1);
        chk("lu_count", stall_count, 1);
        clear_hz();
        step(1);
        ex_MemRead = 1; ex_Rt = 0; id_Rs = 0; #1;
        chk("lu_r0", pc_ld, 1);
        step(1);

        // Rt match only counts when the instruction reads Rt
        ex_Rt = 9; id_Rt = 9; id_Rs = 1; #1;
        chk("lu_rt_unused", pc_ld, 1);
        id_uses_rt = 1; #1;
        chk("lu_rt_used", pc_ld, 0);
        step(1);
        clear_hz();
        step(1);

        // load-use beats branch, then branch flushes from STALL
        ex_MemRead = 1; ex_Rt = 3; id_Rs = 3; branch_taken = 1; #1;
        chk("lu_br_flush", ifid_flush, 0);
        chk("lu_br_pc", pc_ld, 0);
        step(1);
        ex_MemRead = 0; #1;
        chk("br_flush", ifid_flush, 1);
        chk("br_pc", pc_ld, 1);
        step(1);
        clear_hz();
        step(1);
        chk("pre_mult_count", stall_count, 3);

        // multi-cycle freeze with hazards presented during it
        mult_start = 1; #1;
        chk("mult_first_busy", mult_busy, 0);
        chk("mult_first_hold", idex_hold, 1);
        step(1);
        mult_start = 0; branch_taken = 1; ex_MemRead = 1; ex_Rt = 3; id_Rs = 3;
        for (int i = 0; i < LAT - 1; i++) begin
            #1;
            chk("mult_busy_run", mult_busy, 1);
            chk("mult_no_flush", ifid_flush, 0);
            step(1);
        end
        clear_hz(); #1;
        chk("mult_done_pc", pc_ld, 1);
        chk("mult_count", stall_count, 7);
        step(1);

        // mult_start taken from STALL
        ex_MemRead = 1; ex_Rt = 4; id_Rs = 4;
        step(1);
        clear_hz(); mult_start = 1; #1;
        chk("stall_mult_pc", pc_ld, 0);
        step(1);
        mult_start = 0;
        step(LAT - 1);
        chk("stall_mult_count", stall_count, 12);
        step(1);

        // reset during the 2nd MULT cycle
        mult_start = 1;
        step(1);
        mult_start = 0;
        step(1);
        chk("pre_abort_busy", mult_busy, 1);
        rst = 0; #1;
        chk("abort_busy", mult_busy, 0);
        chk("abort_count", stall_count, 0);
        chk("abort_bubble", idex_bubble, 1);
        step(1);
        rst = 1; #1;
        chk("post_rst_pc", pc_ld, 1);
        chk("post_rst_busy", mult_busy, 0);
        step(2);

        // 20 load-use stalls: narrow counter saturates
        for (int i = 0; i < 20; i++) begin
            ex_MemRead = 1; ex_Rt = 2; id_Rs = 2;
            step(1);
            clear_hz();
            step(1);
        end
        chk("sat_15", s_stall_count, 15);
        chk("wide_20", stall_count, 20);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
